// File: rtl/simple_processor_pkg.sv
// Shared widths, shift instruction encodings and pipeline payload types
// for the shift issue path.
package simple_processor_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);
  localparam int REG_AW      = 5;

  typedef enum logic [3:0] {
    INSTR_ADD  = 4'd0,
    INSTR_SUB  = 4'd1,
    INSTR_SLL  = 4'd2,
    INSTR_SLLI = 4'd3,
    INSTR_SRL  = 4'd4,
    INSTR_SRLI = 4'd5,
    INSTR_SRA  = 4'd6,
    INSTR_SRAI = 4'd7,
    INSTR_AND  = 4'd8,
    INSTR_OR   = 4'd9
  } instr_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [SHIFT_WIDTH-1:0] amt;
    logic                   left;
    logic                   arith;
    logic [REG_AW-1:0]      rd;
  } shift_op_t;

  typedef struct packed {
    logic [REG_AW-1:0]     rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic is_imm_form(instr_t f);
    return (f == INSTR_SLLI) || (f == INSTR_SRLI) || (f == INSTR_SRAI);
  endfunction

endpackage

// File: rtl/shift_wb_fifo.sv
// Small synchronous writeback FIFO with flush, occupancy count and
// simultaneous push/pop (a push into a full FIFO is allowed when it also pops).
module shift_wb_fifo
  import simple_processor_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  wb_entry_t                push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/shift_issue_ctrl.sv
// Initiator side of the shift datapath: decodes shift requests into an issue
// register driving the external shifter, and queues results as writebacks.
module shift_issue_ctrl
  import simple_processor_pkg::*;
#(
  parameter int WB_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  instr_t                      req_func_i,
  input  logic [DATA_WIDTH-1:0]       req_rs1_i,
  input  logic [DATA_WIDTH-1:0]       req_rs2_i,
  input  logic [DATA_WIDTH-1:0]       req_imm_i,
  input  logic [REG_AW-1:0]           req_rd_i,
  input  logic                        flush_i,
  output logic                        sh_valid_o,
  output logic [DATA_WIDTH-1:0]       sh_data_o,
  output logic [SHIFT_WIDTH-1:0]      sh_amt_o,
  output logic                        sh_left_o,
  output logic                        sh_arith_o,
  input  logic [DATA_WIDTH-1:0]       sh_result_i,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [REG_AW-1:0]           wb_rd_o,
  output logic [DATA_WIDTH-1:0]       wb_data_o,
  output logic                        illegal_o,
  output logic [$clog2(WB_DEPTH):0]   wb_count_o
);

  logic      issue_valid_q, issue_valid_d;
  shift_op_t issue_op_q, issue_op_d;
  logic      illegal_q, illegal_d;

  shift_op_t req_op;
  logic      req_legal;
  logic      req_fire;
  logic      issue_adv;
  logic      wb_push, wb_pop;
  logic      fifo_full;
  wb_entry_t wb_head;
  wb_entry_t wb_new;

  // Only the low SHIFT_WIDTH bits of either shift-amount source matter.
  logic unused_amt_bits;
  assign unused_amt_bits = ^{req_rs2_i[DATA_WIDTH-1:SHIFT_WIDTH],
                             req_imm_i[DATA_WIDTH-1:SHIFT_WIDTH]};

  always_comb begin
    req_legal    = 1'b1;
    req_op       = '0;
    req_op.data  = req_rs1_i;
    req_op.rd    = req_rd_i;
    req_op.amt   = is_imm_form(req_func_i) ? req_imm_i[SHIFT_WIDTH-1:0]
                                           : req_rs2_i[SHIFT_WIDTH-1:0];
    case (req_func_i)
      INSTR_SLL, INSTR_SLLI: req_op.left  = 1'b1;
      INSTR_SRL, INSTR_SRLI: req_op.left  = 1'b0;
      INSTR_SRA, INSTR_SRAI: req_op.arith = 1'b1;
      default:               req_legal    = 1'b0;
    endcase
  end

  assign wb_pop      = wb_valid_o & wb_ready_i;
  assign issue_adv   = issue_valid_q & (~fifo_full | wb_pop);
  assign req_ready_o = ~issue_valid_q | issue_adv;
  assign req_fire    = req_valid_i & req_ready_o;

  // x0 results are still shifted but never written back.
  assign wb_push     = issue_adv & (issue_op_q.rd != '0);
  assign wb_new.rd   = issue_op_q.rd;
  assign wb_new.data = sh_result_i;

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_op_d    = issue_op_q;
    illegal_d     = 1'b0;
    if (issue_adv) begin
      issue_valid_d = 1'b0;
    end
    if (req_fire) begin
      if (req_legal) begin
        issue_valid_d = 1'b1;
        issue_op_d    = req_op;
      end else begin
        illegal_d = 1'b1;
      end
    end
    if (flush_i) begin
      issue_valid_d = 1'b0;
      illegal_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      illegal_q     <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_op_q    <= issue_op_d;
      illegal_q     <= illegal_d;
    end
  end

  assign sh_valid_o = issue_valid_q;
  assign sh_data_o  = issue_op_q.data;
  assign sh_amt_o   = issue_op_q.amt;
  assign sh_left_o  = issue_op_q.left;
  assign sh_arith_o = issue_op_q.arith;
  assign illegal_o  = illegal_q;

  shift_wb_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (wb_push),
    .push_data_i (wb_new),
    .pop_i       (wb_pop),
    .valid_o     (wb_valid_o),
    .head_o      (wb_head),
    .full_o      (fifo_full),
    .count_o     (wb_count_o)
  );

  assign wb_rd_o   = wb_head.rd;
  assign wb_data_o = wb_head.data;

endmodule
